subleq_control_card: RTL and testbench
======================================

Name: subleq_control_card

Overview:
- Sequencer card for the SUBLEQ bus machine: it is the initiator that drives the shared control bus, and the register card and memory card respond to it.
- Runs the instruction cycle: fetch A, fetch B, read mem[A] and mem[B], write mem[B] = mem[B] - mem[A], then branch to C if the result is <= 0, else PC+1.
- Holds the operand and result latches. It drives the data bus during PC increments and memory write-back.
- Reads the address bus, which the register card drives, to compute PC+1.

Parameters:
- DATAWIDTH, `DATAWIDTH: width of the data and address buses and of the arithmetic.
- CTRLWIDTH, `CTRLWIDTH: control bus width, >= 6. Bits above 5 are driven 0.

Ports:
- clk  input  1  system clock. This card acts on posedge; bus responders sample on negedge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  permits the start of a new instruction.
- data_in  input  DATAWIDTH  data bus value (memory read data).
- data_out  output  DATAWIDTH  value this card places on the data bus.
- data_oe  output  1  data bus drive enable. data_out is meaningful only when this is 1.
- addr  input  DATAWIDTH  address bus, driven by the register card.
- ctrl  output  CTRLWIDTH  control bus. Field positions are fixed:
  - [1:0] REG_WR (`CTRL_REG_WR)
  - [3:2] REG_RD (`CTRL_REG_RD)
  - [4] MEM_RD
  - [5] MEM_WR
  - Register codes: `REG_NONE=0, `REG_PC, `REG_A, `REG_B.
- halted  output  1  high once a halt branch has been taken.
- instr_done  output  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; op_a=0, op_b=0, result=0; halted=0; instr_done=0.
  - ctrl=0, data_oe=0, data_out=0, all immediately.
  - Reset mid-instruction aborts with no further bus writes. Register and memory state is whatever was committed before reset.
- Output decoding:
  - ctrl, data_oe and halted decode from the state register only.
  - data_out is addr+1 (modulo 2^DATAWIDTH) in the INC states, result in WRITE_B, and 0 otherwise.
- State sequence: one state per clk cycle; outputs listed are those held during the state.
  - IDLE: ctrl=0. Goes to PCA_SET if run=1, else stays.
  - PCA_SET: RD=PC.
  - LOAD_A: RD=PC, MEM_RD, WR=A.
  - INC1: RD=PC, WR=PC, data_oe=1, data_out=addr+1.
  - PCB_SET: RD=PC.
  - LOAD_B: RD=PC, MEM_RD, WR=B.
  - INC2: same outputs as INC1.
  - RDA_SET: RD=A.
  - READ_A: RD=A, MEM_RD. op_a <= data_in at the closing posedge.
  - RDB_SET: RD=B.
  - READ_B: RD=B, MEM_RD. At the closing posedge: op_b <= data_in and result <= data_in - op_a.
  - WRITE_B: RD=B, MEM_WR, data_oe=1, data_out=result.
  - PCC_SET: RD=PC.
  - BRANCH, with taken = (result==0) or result[MSB]:
    - Taken: RD=PC, MEM_RD, WR=PC, so PC <= C.
    - Not taken: INC outputs, so PC <= PC+1.
    - At the closing posedge: if taken and data_in is all-ones, go to HALT; otherwise go to IDLE. instr_done is set for one cycle in both cases.
  - HALT: ctrl=0, data_oe=0, halted=1. Stays until rst.
- Timing:
  - Every SET state exists so that the register card's negedge-latched addr output is valid before the transfer state.
  - With run held at 1, an instruction takes exactly 14 cycles (IDLE through BRANCH).
- Arithmetic:
  - Subtraction wraps modulo 2^DATAWIDTH.
  - The sign test is two's-complement on the wrapped result.
- run:
  - Sampled only in IDLE. Deasserting it mid-instruction does not stop the current instruction.
  - The card parks in IDLE after BRANCH completes.
- data_oe is never 1 in a state that asserts MEM_RD (no bus contention).

Test Plan:
Bench uses DATAWIDTH=16, a negedge register-card model and a combinational-read / negedge-write memory.
- Not-taken: mem[0..2]={3,4,0}, mem[3]=5, mem[4]=7, run=1 -> after 14 cycles mem[4]=2, PC=3, instr_done pulses once, halted=0.
- Taken on zero: mem[0..2]={3,3,9}, mem[3]=6 -> mem[3]=0, PC=9.
- Taken on negative with wrap: mem[0..2]={3,4,0x20}, mem[3]=1, mem[4]=0x8000 -> mem[4]=0x7FFF, not taken, PC=3. Then a second case with mem[4]=0 -> mem[4]=0xFFFF, taken, PC=0x20.
- Halt: mem[0..2]={3,3,0xFFFF} -> halted=1 after BRANCH, ctrl=0 thereafter, PC=0xFFFF.
- run gating: drop run at cycle 5 of an instruction -> that instruction completes, and the card then stays in IDLE with ctrl=0 until run=1.
- Async reset: assert rst during WRITE_B -> ctrl=0 and data_oe=0 in the same cycle with no clock edge, mem[B] unchanged, and after release the card sits in IDLE.

Source files
------------

// File: rtl/subleq_control_card.sv
// ============================================================================
// subleq_control_card : SUBLEQ bus sequencer (fetch, subtract, write, branch)
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 8
`endif
`ifndef CTRL_REG_WR
`define CTRL_REG_WR 1:0
`endif
`ifndef CTRL_REG_RD
`define CTRL_REG_RD 3:2
`endif
`ifndef CTRL_MEM_RD
`define CTRL_MEM_RD 4
`endif
`ifndef CTRL_MEM_WR
`define CTRL_MEM_WR 5
`endif
`ifndef REG_NONE
`define REG_NONE 2'd0
`endif
`ifndef REG_PC
`define REG_PC 2'd1
`endif
`ifndef REG_A
`define REG_A 2'd2
`endif
`ifndef REG_B
`define REG_B 2'd3
`endif

module subleq_control_card #(
  parameter int DATAWIDTH = `DATAWIDTH,
  parameter int CTRLWIDTH = `CTRLWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 data_oe,
  input  logic [DATAWIDTH-1:0] addr,
  output logic [CTRLWIDTH-1:0] ctrl,
  output logic                 halted,
  output logic                 instr_done
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PCA_SET = 4'd1,
    ST_LOAD_A  = 4'd2,
    ST_INC1    = 4'd3,
    ST_PCB_SET = 4'd4,
    ST_LOAD_B  = 4'd5,
    ST_INC2    = 4'd6,
    ST_RDA_SET = 4'd7,
    ST_READ_A  = 4'd8,
    ST_RDB_SET = 4'd9,
    ST_READ_B  = 4'd10,
    ST_WRITE_B = 4'd11,
    ST_PCC_SET = 4'd12,
    ST_BRANCH  = 4'd13,
    ST_HALT    = 4'd14
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] op_a_q, op_a_d;
  logic [DATAWIDTH-1:0] op_b_q, op_b_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic                 instr_done_q, instr_done_d;

  logic [1:0]           reg_wr;
  logic [1:0]           reg_rd;
  logic                 mem_rd;
  logic                 mem_wr;
  logic                 branch_taken;
  logic [DATAWIDTH-1:0] addr_inc;

  assign branch_taken = (result_q == '0) || result_q[DATAWIDTH-1];
  assign addr_inc     = addr + DATAWIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      instr_done_q <= instr_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    instr_done_d = 1'b0;
    reg_wr       = `REG_NONE;
    reg_rd       = `REG_NONE;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    data_oe      = 1'b0;
    data_out     = '0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_PCA_SET;
      end
      ST_PCA_SET: begin
        reg_rd  = `REG_PC;
        state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        reg_rd  = `REG_PC;
        mem_rd  = 1'b1;
        reg_wr  = `REG_A;
        state_d = ST_INC1;
      end
      ST_INC1: begin
        reg_rd   = `REG_PC;
        reg_wr   = `REG_PC;
        data_oe  = 1'b1;
        data_out = addr_inc;
        state_d  = ST_PCB_SET;
      end
      ST_PCB_SET: begin
        reg_rd  = `REG_PC;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        reg_rd  = `REG_PC;
        mem_rd  = 1'b1;
        reg_wr  = `REG_B;
        state_d = ST_INC2;
      end
      ST_INC2: begin
        reg_rd   = `REG_PC;
        reg_wr   = `REG_PC;
        data_oe  = 1'b1;
        data_out = addr_inc;
        state_d  = ST_RDA_SET;
      end
      ST_RDA_SET: begin
        reg_rd  = `REG_A;
        state_d = ST_READ_A;
      end
      ST_READ_A: begin
        reg_rd  = `REG_A;
        mem_rd  = 1'b1;
        op_a_d  = data_in;
        state_d = ST_RDB_SET;
      end
      ST_RDB_SET: begin
        reg_rd  = `REG_B;
        state_d = ST_READ_B;
      end
      ST_READ_B: begin
        reg_rd   = `REG_B;
        mem_rd   = 1'b1;
        op_b_d   = data_in;
        result_d = data_in - op_a_q;
        state_d  = ST_WRITE_B;
      end
      ST_WRITE_B: begin
        reg_rd   = `REG_B;
        mem_wr   = 1'b1;
        data_oe  = 1'b1;
        data_out = result_q;
        state_d  = ST_PCC_SET;
      end
      ST_PCC_SET: begin
        reg_rd  = `REG_PC;
        state_d = ST_BRANCH;
      end
      ST_BRANCH: begin
        // Taken loads C from memory into PC; not taken reuses the increment path.
        reg_rd       = `REG_PC;
        reg_wr       = `REG_PC;
        instr_done_d = 1'b1;
        if (branch_taken) begin
          mem_rd  = 1'b1;
          state_d = (data_in == '1) ? ST_HALT : ST_IDLE;
        end else begin
          data_oe  = 1'b1;
          data_out = addr_inc;
          state_d  = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ctrl                = '0;
    ctrl[`CTRL_REG_WR]  = reg_wr;
    ctrl[`CTRL_REG_RD]  = reg_rd;
    ctrl[`CTRL_MEM_RD]  = mem_rd;
    ctrl[`CTRL_MEM_WR]  = mem_wr;
  end

  assign halted     = (state_q == ST_HALT);
  assign instr_done = instr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_subleq_control_card.sv
// Bench for subleq_control_card with a negedge register-card model and a
// combinational-read / negedge-write memory.
`default_nettype none

module tb_subleq_control_card;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] data_out;
  logic        data_oe;
  logic [7:0]  ctrl;
  logic        halted;
  logic        instr_done;
  logic [15:0] bus;

  logic [15:0] pc, ra, rb, reg_addr;
  logic [15:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_data = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign bus = data_oe ? data_out : (ctrl[4] ? mem[reg_addr[7:0]] : 16'h0000);

  subleq_control_card #(.DATAWIDTH(16), .CTRLWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .data_in    (bus),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .addr       (reg_addr),
    .ctrl       (ctrl),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // Register card: latches addr and register writes on negedge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      pc <= 16'h0; ra <= 16'h0; rb <= 16'h0; reg_addr <= 16'h0;
    end else begin
      case (ctrl[3:2])
        2'd1: reg_addr <= pc;
        2'd2: reg_addr <= ra;
        2'd3: reg_addr <= rb;
        default: reg_addr <= reg_addr;
      endcase
      case (ctrl[1:0])
        2'd1: pc <= bus;
        2'd2: ra <= bus;
        2'd3: rb <= bus;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (!rst && ctrl[5]) mem[reg_addr[7:0]] <= bus;
  end

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(negedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic setup(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                       input logic [15:0] w3, input logic [15:0] w4);
    rst = 1'b1; run = 1'b0;
    load(8'd0, w0); load(8'd1, w1); load(8'd2, w2); load(8'd3, w3); load(8'd4, w4);
    @(negedge clk);
    rst = 1'b0; run = 1'b1; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (instr_done) done_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    steps(2);
    n_cmp++; if (ctrl !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got %h want 00", ctrl); end
    n_cmp++; if (data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", data_oe); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_dout got %h want 0000", data_out); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (instr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", instr_done); end
    run = 1'b0;
  endtask

  task automatic test_not_taken();
    logic [7:0] exp_ctrl [0:12] = '{8'h04, 8'h16, 8'h05, 8'h04, 8'h17, 8'h05, 8'h08,
                                   8'h18, 8'h0C, 8'h1C, 8'h2C, 8'h04, 8'h05};
    setup(16'd3, 16'd4, 16'd0, 16'd5, 16'd7);
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 0) run = 1'b0;
      n_cmp++;
      if (ctrl !== exp_ctrl[k]) begin
        n_bad++; $display("FAIL nt_ctrl step %0d got %h want %h", k + 1, ctrl, exp_ctrl[k]);
      end
      if (k == 2) begin
        n_cmp++;
        if (data_oe !== 1'b1 || data_out !== 16'd1) begin
          n_bad++; $display("FAIL nt_inc1 got oe=%b dout=%h want oe=1 dout=0001", data_oe, data_out);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (data_oe !== 1'b1 || data_out !== 16'd2) begin
          n_bad++; $display("FAIL nt_wrb got oe=%b dout=%h want oe=1 dout=0002", data_oe, data_out);
        end
      end
    end
    step();
    n_cmp++; if (instr_done !== 1'b1) begin n_bad++; $display("FAIL nt_done got %b want 1", instr_done); end
    n_cmp++; if (mem[4] !== 16'd2) begin n_bad++; $display("FAIL nt_mem4 got %h want 0002", mem[4]); end
    n_cmp++; if (pc !== 16'd3) begin n_bad++; $display("FAIL nt_pc got %h want 0003", pc); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL nt_halted got %b want 0", halted); end
    steps(3);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL nt_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (ctrl !== 8'h00) begin n_bad++; $display("FAIL nt_idle_ctrl got %h want 00", ctrl); end
  endtask

  task automatic test_taken_zero();
    setup(16'd3, 16'd3, 16'd9, 16'd6, 16'd0);
    step(); run = 1'b0;
    steps(12);
    n_cmp++; if (ctrl !== 8'h15) begin n_bad++; $display("FAIL tz_branch_ctrl got %h want 15", ctrl); end
    n_cmp++; if (data_oe !== 1'b0) begin n_bad++; $display("FAIL tz_branch_oe got %b want 0", data_oe); end
    step();
    n_cmp++; if (mem[3] !== 16'd0) begin n_bad++; $display("FAIL tz_mem3 got %h want 0000", mem[3]); end
    n_cmp++; if (pc !== 16'd9) begin n_bad++; $display("FAIL tz_pc got %h want 0009", pc); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL tz_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    setup(16'd3, 16'd4, 16'h0020, 16'd1, 16'h8000);
    step(); run = 1'b0;
    steps(13);
    n_cmp++; if (mem[4] !== 16'h7FFF) begin n_bad++; $display("FAIL wr1_mem4 got %h want 7fff", mem[4]); end
    n_cmp++; if (pc !== 16'd3) begin n_bad++; $display("FAIL wr1_pc got %h want 0003", pc); end
    setup(16'd3, 16'd4, 16'h0020, 16'd1, 16'h0000);
    step(); run = 1'b0;
    steps(13);
    n_cmp++; if (mem[4] !== 16'hFFFF) begin n_bad++; $display("FAIL wr2_mem4 got %h want ffff", mem[4]); end
    n_cmp++; if (pc !== 16'h0020) begin n_bad++; $display("FAIL wr2_pc got %h want 0020", pc); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL wr2_halted got %b want 0", halted); end
  endtask

  task automatic test_halt();
    setup(16'd3, 16'd3, 16'hFFFF, 16'd0, 16'd0);
    steps(14);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL h_halted got %b want 1", halted); end
    n_cmp++; if (pc !== 16'hFFFF) begin n_bad++; $display("FAIL h_pc got %h want ffff", pc); end
    n_cmp++; if (instr_done !== 1'b1) begin n_bad++; $display("FAIL h_done got %b want 1", instr_done); end
    steps(5);
    n_cmp++;
    if (halted !== 1'b1 || ctrl !== 8'h00 || data_oe !== 1'b0) begin
      n_bad++; $display("FAIL h_stay got halted=%b ctrl=%h oe=%b want 1/00/0", halted, ctrl, data_oe);
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL h_done_cnt got %0d want 1", done_cnt); end
    run = 1'b0;
  endtask

  task automatic test_run_gating();
    int nonidle;
    setup(16'd3, 16'd4, 16'd0, 16'd5, 16'd7);
    steps(5);
    run = 1'b0;
    steps(9);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rg_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (mem[4] !== 16'd2) begin n_bad++; $display("FAIL rg_mem4 got %h want 0002", mem[4]); end
    nonidle = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ctrl !== 8'h00) nonidle++;
    end
    n_cmp++; if (nonidle !== 0) begin n_bad++; $display("FAIL rg_parked got %0d busy cycles want 0", nonidle); end
    run = 1'b1;
    step();
    run = 1'b0;
    n_cmp++; if (ctrl !== 8'h04) begin n_bad++; $display("FAIL rg_restart_ctrl got %h want 04", ctrl); end
    steps(14);
  endtask

  task automatic test_async_reset();
    setup(16'd3, 16'd4, 16'd0, 16'd5, 16'd7);
    step(); run = 1'b0;
    steps(10);
    n_cmp++; if (ctrl !== 8'h2C) begin n_bad++; $display("FAIL ar_wrb_ctrl got %h want 2c", ctrl); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'h00) begin n_bad++; $display("FAIL ar_ctrl got %h want 00", ctrl); end
    n_cmp++; if (data_oe !== 1'b0) begin n_bad++; $display("FAIL ar_oe got %b want 0", data_oe); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL ar_dout got %h want 0000", data_out); end
    steps(3);
    n_cmp++; if (mem[4] !== 16'd7) begin n_bad++; $display("FAIL ar_mem4 got %h want 0007", mem[4]); end
    @(negedge clk);
    rst = 1'b0; done_cnt = 0;
    steps(4);
    n_cmp++;
    if (ctrl !== 8'h00 || halted !== 1'b0 || done_cnt !== 0) begin
      n_bad++; $display("FAIL ar_idle got ctrl=%h halted=%b done=%0d want 00/0/0", ctrl, halted, done_cnt);
    end
    n_cmp++; if (mem[4] !== 16'd7) begin n_bad++; $display("FAIL ar_mem4_after got %h want 0007", mem[4]); end
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_taken_zero();
    test_wrap();
    test_halt();
    test_run_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
